// File: rtl/cordic_pkg.sv
// Shared Q8.24 angle constants, quadrant type and quadrant-reduction helper.
package cordic_pkg;

    localparam int unsigned INT_W  = 8;
    localparam int unsigned FRAC_W = 24;

    typedef logic [INT_W+FRAC_W-1:0] q_t;
    typedef logic [1:0]              k_t;

    typedef struct packed {
        k_t k;
        q_t theta;
    } quad_t;

    // Every multiple of PI/4 is built from PI with shifts and adds, so all
    // boundaries share the same rounding.
    localparam q_t PI     = 32'h0324_3F6B;
    localparam q_t PI_2   = PI >> 1;
    localparam q_t PI_4   = PI >> 2;
    localparam q_t TWO_PI = PI << 1;
    localparam q_t PI3_4  = PI_2 + PI_4;
    localparam q_t PI5_4  = PI + PI_4;
    localparam q_t PI3_2  = PI + PI_2;
    localparam q_t PI7_4  = PI3_2 + PI_4;

    // Map an angle in [0, 2PI) onto a quadrant and a residual in [-PI/4, PI/4].
    function automatic quad_t quad_reduce(input q_t a);
        quad_t q;
        if (a < PI_4) begin
            q.k     = 2'd0;
            q.theta = a;
        end else if (a < PI3_4) begin
            q.k     = 2'd1;
            q.theta = a - PI_2;
        end else if (a < PI5_4) begin
            q.k     = 2'd2;
            q.theta = a - PI;
        end else if (a < PI7_4) begin
            q.k     = 2'd3;
            q.theta = a - PI3_2;
        end else begin
            q.k     = 2'd0;
            q.theta = a - TWO_PI;
        end
        return q;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with synchronous reset; the head entry is read straight
// from the storage flops, so the output is registered.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full;
    logic             do_pop;

    assign empty  = (count_q == '0);
    assign full   = (count_q == CW'(DEPTH));
    assign do_pop = pop && !empty;
    assign rdata  = mem_q[rd_ptr_q];

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        count_d = count_q + CW'(push) - CW'(do_pop);
    end

    // State registers; storage is cleared so the head reads zero after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Upstream credit accounting must keep every push off a full FIFO.
    assert property (@(posedge clk) disable iff (reset) !(push && full));

endmodule

// File: rtl/cordic_sched.sv
// Two-requester round-robin scheduler in front of a fixed-latency CORDIC
// rotation pipeline, with credit flow control and in-order result return.
module cordic_sched
    import cordic_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned PIPE_LAT   = 5,
    parameter int unsigned WARMUP     = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [1:0][31:0] req_angle,
    input  logic [1:0][31:0] req_amp,
    output logic             cd_enable_in,
    output logic [31:0]      cd_s_re,
    output logic [31:0]      cd_s_theta,
    output logic [1:0]       cd_k_in,
    input  logic             cd_enable_out,
    input  logic [31:0]      cd_x_re,
    input  logic [31:0]      cd_x_im,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_id,
    output logic [31:0]      res_re,
    output logic [31:0]      res_im,
    output logic             err_range,
    output logic             err_orphan
);

    localparam int unsigned CRW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned WW  = $clog2(WARMUP + 2);
    localparam int unsigned LW  = $clog2(PIPE_LAT + 2);

    logic [CRW-1:0] credit_q, credit_d;
    logic [WW-1:0]  warm_q, warm_d;
    logic [LW-1:0]  ign_q, ign_d;
    logic           prio_q, prio_d;
    logic           cd_enable_in_q, cd_enable_in_d;
    q_t             cd_s_re_q, cd_s_re_d;
    q_t             cd_s_theta_q, cd_s_theta_d;
    k_t             cd_k_in_q, cd_k_in_d;
    logic           err_range_q, err_range_d;
    logic           err_orphan_q, err_orphan_d;

    logic           eligible, accept, grant_id, range_hit;
    q_t             a_raw, a_red;
    quad_t          quad;
    logic           pipe_ret, tag_id, tag_empty, tag_pop;
    logic           res_empty, res_pop;
    logic [64:0]    res_data;

    // Arbitration, angle reduction and next-state for all scheduler registers.
    always_comb begin
        eligible  = !reset && (warm_q == '0) && (credit_q < CRW'(FIFO_DEPTH));
        grant_id  = (req_valid == 2'b11) ? prio_q : req_valid[1];
        accept    = eligible && (req_valid != 2'b00);
        req_ready = '0;
        if (accept) begin
            req_ready[grant_id] = 1'b1;
        end

        a_raw     = req_angle[grant_id];
        range_hit = (a_raw >= TWO_PI);
        a_red     = range_hit ? a_raw - TWO_PI : a_raw;
        quad      = quad_reduce(a_red);

        // Returns during the post-reset window belong to discarded requests.
        pipe_ret = cd_enable_out && (ign_q == '0);
        tag_pop  = pipe_ret && !tag_empty;
        res_pop  = res_valid && res_ready;

        warm_d         = (warm_q != '0) ? warm_q - 1'b1 : warm_q;
        ign_d          = (ign_q != '0) ? ign_q - 1'b1 : ign_q;
        prio_d         = accept ? !grant_id : prio_q;
        credit_d       = credit_q + CRW'(accept) - CRW'(res_pop);
        cd_enable_in_d = accept;
        cd_s_re_d      = accept ? req_amp[grant_id] : cd_s_re_q;
        cd_s_theta_d   = accept ? quad.theta : cd_s_theta_q;
        cd_k_in_d      = accept ? quad.k : cd_k_in_q;
        err_range_d    = err_range_q || (accept && range_hit);
        err_orphan_d   = err_orphan_q || (pipe_ret && tag_empty);
    end

    // Scheduler state and registered pipeline drive.
    always_ff @(posedge clk) begin
        if (reset) begin
            credit_q       <= '0;
            warm_q         <= WW'(WARMUP);
            ign_q          <= LW'(PIPE_LAT);
            prio_q         <= 1'b0;
            cd_enable_in_q <= 1'b0;
            cd_s_re_q      <= '0;
            cd_s_theta_q   <= '0;
            cd_k_in_q      <= '0;
            err_range_q    <= 1'b0;
            err_orphan_q   <= 1'b0;
        end else begin
            credit_q       <= credit_d;
            warm_q         <= warm_d;
            ign_q          <= ign_d;
            prio_q         <= prio_d;
            cd_enable_in_q <= cd_enable_in_d;
            cd_s_re_q      <= cd_s_re_d;
            cd_s_theta_q   <= cd_s_theta_d;
            cd_k_in_q      <= cd_k_in_d;
            err_range_q    <= err_range_d;
            err_orphan_q   <= err_orphan_d;
        end
    end

    // Requester ids of issued rotations, in issue order.
    sync_fifo #(
        .WIDTH (1),
        .DEPTH (FIFO_DEPTH)
    ) u_tag_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (accept),
        .wdata (grant_id),
        .pop   (tag_pop),
        .rdata (tag_id),
        .empty (tag_empty)
    );

    // Completed results waiting for the consumer.
    sync_fifo #(
        .WIDTH (65),
        .DEPTH (FIFO_DEPTH)
    ) u_res_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tag_pop),
        .wdata ({tag_id, cd_x_re, cd_x_im}),
        .pop   (res_pop),
        .rdata (res_data),
        .empty (res_empty)
    );

    assign cd_enable_in = cd_enable_in_q;
    assign cd_s_re      = cd_s_re_q;
    assign cd_s_theta   = cd_s_theta_q;
    assign cd_k_in      = cd_k_in_q;
    assign err_range    = err_range_q;
    assign err_orphan   = err_orphan_q;
    assign res_valid    = !res_empty;
    assign res_id       = res_data[64];
    assign res_re       = res_data[63:32];
    assign res_im       = res_data[31:0];

endmodule

// File: tb/tb_cordic_sched.sv
// Directed bench for cordic_sched with a behavioural rotation pipeline.
module tb_cordic_sched;

    localparam int unsigned PIPE_LAT = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0][31:0] req_angle;
    logic [1:0][31:0] req_amp;
    logic             cd_enable_in;
    logic [31:0]      cd_s_re;
    logic [31:0]      cd_s_theta;
    logic [1:0]       cd_k_in;
    logic             cd_enable_out;
    logic [31:0]      cd_x_re;
    logic [31:0]      cd_x_im;
    logic             res_valid;
    logic             res_ready;
    logic             res_id;
    logic [31:0]      res_re;
    logic [31:0]      res_im;
    logic             err_range;
    logic             err_orphan;
    logic             force_en;

    int n_tests = 0;
    int n_fail  = 0;
    int acc_cnt = 0;
    logic [64:0] res_log [$];

    // Quadrant vectors: angle, expected k, expected theta.
    logic [31:0] qa [7] = '{32'h00C90FD9, 32'h00C90FDA, 32'h025B2F8F, 32'h03243F6B,
                            32'h04000000, 32'h06000000, 32'h06487ED5};
    logic [1:0]  qk [7] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd3, 2'd0, 2'd0};
    logic [31:0] qt [7] = '{32'h00C90FD9, 32'hFF36F025, 32'hFF36F024, 32'h00000000,
                            32'hFF49A0E0, 32'hFFB7812A, 32'hFFFFFFFF};

    always #5 clk = ~clk;

    cordic_sched #(
        .FIFO_DEPTH (8),
        .PIPE_LAT   (PIPE_LAT),
        .WARMUP     (5)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_angle     (req_angle),
        .req_amp       (req_amp),
        .cd_enable_in  (cd_enable_in),
        .cd_s_re       (cd_s_re),
        .cd_s_theta    (cd_s_theta),
        .cd_k_in       (cd_k_in),
        .cd_enable_out (cd_enable_out),
        .cd_x_re       (cd_x_re),
        .cd_x_im       (cd_x_im),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_id        (res_id),
        .res_re        (res_re),
        .res_im        (res_im),
        .err_range     (err_range),
        .err_orphan    (err_orphan)
    );

    // Ideal rotation: amp * e^(j*theta), then k exact quarter turns.
    function automatic logic [63:0] rotate(input logic [31:0] amp, input logic [31:0] theta,
                                           input logic [1:0] k);
        real x, th;
        int  ire, iim, t;
        x   = $itor($signed(amp));
        th  = $itor($signed(theta)) / 16777216.0;
        ire = $rtoi(x * $cos(th));
        iim = $rtoi(x * $sin(th));
        for (int i = 0; i < int'(k); i++) begin
            t   = ire;
            ire = -iim;
            iim = t;
        end
        return {ire, iim};
    endfunction

    // Rotation pipeline model; deliberately unaffected by the DUT reset.
    logic        pipe_en [PIPE_LAT] = '{default: 1'b0};
    logic [31:0] pipe_re [PIPE_LAT] = '{default: 32'h0};
    logic [31:0] pipe_im [PIPE_LAT] = '{default: 32'h0};

    always @(posedge clk) begin
        for (int i = PIPE_LAT - 1; i > 0; i--) begin
            pipe_en[i] <= pipe_en[i-1];
            pipe_re[i] <= pipe_re[i-1];
            pipe_im[i] <= pipe_im[i-1];
        end
        pipe_en[0]               <= cd_enable_in;
        {pipe_re[0], pipe_im[0]} <= rotate(cd_s_re, cd_s_theta, cd_k_in);
    end

    assign cd_enable_out = pipe_en[PIPE_LAT-1] | force_en;
    assign cd_x_re       = pipe_re[PIPE_LAT-1];
    assign cd_x_im       = pipe_im[PIPE_LAT-1];

    // Record acceptances and delivered results.
    always @(posedge clk) begin
        if (!reset && ((req_valid & req_ready) != 2'b00)) acc_cnt <= acc_cnt + 1;
        if (!reset && res_valid && res_ready) res_log.push_back({res_id, res_re, res_im});
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_log(input int n);
        int guard = 0;
        while (res_log.size() < n && guard < 60) begin
            tick();
            guard++;
        end
        check("log_count", res_log.size(), n);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int          lat;
        int          base;
        logic [1:0]  exp_g;
        logic        exp_id;
        logic [64:0] e;

        reset     = 1'b1;
        req_valid = '0;
        req_angle = '0;
        req_amp   = '0;
        res_ready = 1'b1;
        force_en  = 1'b0;
        repeat (2) tick();

        // Reset state with requests pending.
        req_valid = 2'b11;
        #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_cd_en", cd_enable_in, 0);
        check("rst_cd_re", cd_s_re, 0);
        check("rst_cd_theta", cd_s_theta, 0);
        check("rst_cd_k", cd_k_in, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", {res_id, res_re, res_im}, 0);
        check("rst_errs", {err_range, err_orphan}, 0);

        // Warm-up, then a single PI/2 rotation.
        req_valid    = 2'b01;
        req_angle[0] = 32'h01921FB5;
        req_amp[0]   = 32'h01000000;
        reset        = 1'b0;
        #1;
        for (int c = 0; c < 5; c++) begin
            check("warm_ready", req_ready, 0);
            tick();
        end
        check("warm_open", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        check("single_en", cd_enable_in, 1);
        check("single_k", cd_k_in, 1);
        check("single_theta", cd_s_theta, 0);
        check("single_amp", cd_s_re, 32'h01000000);
        lat = 1;
        while (!res_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("single_latency", lat, 7);
        check("single_id", res_id, 0);
        check("single_re", res_re, 0);
        check("single_im", res_im, 32'h01000000);
        tick();
        res_log.delete();

        // Both requesters streaming: priority now with requester 1.
        req_angle  = '0;
        req_amp[0] = 32'h00000A00;
        req_amp[1] = 32'h00000B00;
        req_valid  = 2'b11;
        #1;
        for (int i = 0; i < 6; i++) begin
            exp_g = (i % 2 == 0) ? 2'b10 : 2'b01;
            check("rr_grant", req_ready, exp_g);
            tick();
            check("rr_issue", cd_enable_in, 1);
        end
        req_valid = 2'b00;
        wait_log(6);
        for (int i = 0; i < 6; i++) begin
            exp_id = (i % 2 == 0);
            e      = res_log.pop_front();
            check("rr_res_id", e[64], exp_id);
            check("rr_res_re", e[63:32], exp_id ? 32'h00000B00 : 32'h00000A00);
            check("rr_res_im", e[31:0], 0);
        end

        // Back-pressure: credits cap acceptances at eight.
        res_ready = 1'b0;
        base      = acc_cnt;
        req_valid = 2'b01;
        for (int i = 0; i < 12; i++) begin
            req_amp[0] = 32'h1000 + i;
            tick();
        end
        check("bp_accepts", acc_cnt - base, 8);
        check("bp_ready_low", req_ready, 0);
        repeat (6) tick();
        check("bp_still_low", req_ready, 0);
        check("bp_res_valid", res_valid, 1);
        req_valid = 2'b00;
        res_ready = 1'b1;
        wait_log(8);
        for (int i = 0; i < 8; i++) begin
            e = res_log.pop_front();
            check("bp_res_id", e[64], 0);
            check("bp_res_re", e[63:32], 32'h1000 + i);
        end
        req_valid = 2'b01;
        #1;
        check("bp_resume", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;

        // Quadrant reduction boundaries.
        for (int i = 0; i < 7; i++) begin
            req_angle[0] = qa[i];
            req_amp[0]   = 32'h00800000;
            req_valid    = 2'b01;
            #1;
            check("q_ready", req_ready, 2'b01);
            tick();
            req_valid = 2'b00;
            check("q_en", cd_enable_in, 1);
            check("q_k", cd_k_in, qk[i]);
            check("q_theta", cd_s_theta, qt[i]);
            tick();
        end
        check("q_no_range_err", err_range, 0);

        // Angle of exactly 2PI.
        req_angle[0] = 32'h06487ED6;
        req_valid    = 2'b01;
        tick();
        req_valid = 2'b00;
        check("range_err", err_range, 1);
        check("range_k", cd_k_in, 0);
        check("range_theta", cd_s_theta, 0);

        // Orphan return with the tag queue empty.
        repeat (15) tick();
        res_log.delete();
        check("orphan_pre", err_orphan, 0);
        force_en = 1'b1;
        tick();
        force_en = 1'b0;
        check("orphan_set", err_orphan, 1);
        for (int i = 0; i < 3; i++) begin
            check("orphan_no_res", res_valid, 0);
            tick();
        end

        // Reset with three rotations in flight.
        req_angle  = '0;
        req_amp[0] = 32'h00000111;
        req_amp[1] = 32'h00000222;
        base       = acc_cnt;
        req_valid  = 2'b11;
        repeat (3) tick();
        check("pre_rst_accepts", acc_cnt - base, 3);
        reset = 1'b1;
        tick();
        check("mid_rst_req_ready", req_ready, 0);
        check("mid_rst_cd_en", cd_enable_in, 0);
        check("mid_rst_cd", {cd_s_re, cd_s_theta}, 0);
        check("mid_rst_k", cd_k_in, 0);
        check("mid_rst_res_valid", res_valid, 0);
        check("mid_rst_res_data", {res_id, res_re, res_im}, 0);
        check("mid_rst_errs", {err_range, err_orphan}, 0);
        reset = 1'b0;
        res_log.delete();
        #1;
        for (int c = 0; c < 5; c++) begin
            check("post_rst_ready", req_ready, 0);
            check("post_rst_orphan", err_orphan, 0);
            check("post_rst_res_valid", res_valid, 0);
            tick();
        end
        check("post_rst_first", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        repeat (12) tick();
        check("post_rst_results", res_log.size(), 1);
        if (res_log.size() > 0) begin
            e = res_log.pop_front();
            check("post_rst_id", e[64], 0);
            check("post_rst_re", e[63:32], 32'h00000111);
        end
        check("post_rst_orphan_end", err_orphan, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
